// File: rtl/ahb_arbiter_slave_inst.sv
// ahb_arbiter_slave_inst: per-slave AHB arbiter with burst/lock hold; AHB_ARB_FIXED_PRIO_EN selects fixed priority
module ahb_arbiter_slave_inst #(
  parameter int CHANNEL_NUM = 4,
  parameter int IDX_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                        hclk,
  input  logic                        hreset,
  input  logic [CHANNEL_NUM-1:0]      hreq,
  input  logic [CHANNEL_NUM-1:0][1:0] htrans,
  input  logic [CHANNEL_NUM-1:0][2:0] hburst,
  input  logic [CHANNEL_NUM-1:0]      hmastlock,
  input  logic                        hready,
  output logic [CHANNEL_NUM-1:0]      sel_addr,
  output logic [CHANNEL_NUM-1:0]      sel_data,
  output logic [IDX_W-1:0]            hmaster
);
  logic [CHANNEL_NUM-1:0] sel_addr_q, sel_addr_d, sel_data_q, sel_data_d;
  logic [IDX_W-1:0]       hmaster_q, hmaster_d, win;
  logic [3:0]             rem_q, rem_d, len_m1;
  logic [1:0]             tr;
  logic [2:0]             bu;
  logic                   fixed, hold, arb;
`ifndef AHB_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]       last_q, last_d, cand;
`endif
  // owner's transfer decode: beats left after this edge and whether the grant must stay put
  always_comb begin
    tr = htrans[hmaster_q];
    bu = hburst[hmaster_q];
    fixed = |bu[2:1];
    len_m1 = (bu[2:1] == 2'b01) ? 4'd3 : (bu[2:1] == 2'b10) ? 4'd7 : 4'd15;
    rem_d = !hready ? rem_q :
            (tr == 2'b10 && fixed) ? len_m1 :
            (tr == 2'b11) ? ((rem_q == 4'd0) ? 4'd0 : rem_q - 4'd1) :
            (tr == 2'b01) ? rem_q : 4'd0;
    hold = hmastlock[hmaster_q] | (rem_d != 4'd0) | (tr == 2'b01) | (bu == 3'b001 && tr[1]);
  end
  // winner search; later loop iterations overwrite earlier ones so the highest-priority requester lands last
  always_comb begin
    win = '0;
`ifdef AHB_ARB_FIXED_PRIO_EN
    for (int i = CHANNEL_NUM - 1; i >= 0; i--)
      if (hreq[i]) win = IDX_W'(i);
`else
    cand = '0;
    for (int i = CHANNEL_NUM; i >= 1; i--) begin
      cand = IDX_W'((int'(last_q) + i) % CHANNEL_NUM);
      if (hreq[cand]) win = cand;
    end
`endif
  end
  // next-state: everything freezes while the slave stalls; grant moves only on an unheld accepted edge
  always_comb begin
    arb = hready & ~hold & (|hreq);
    sel_data_d = hready ? sel_addr_q : sel_data_q;
    sel_addr_d = arb ? (CHANNEL_NUM'(1) << win) : sel_addr_q;
    hmaster_d = arb ? win : hmaster_q;
`ifndef AHB_ARB_FIXED_PRIO_EN
    last_d = arb ? win : last_q;
`endif
  end
  // state registers with synchronous reset parking channel 0
  always_ff @(posedge hclk) begin
    if (hreset) begin
      sel_addr_q <= CHANNEL_NUM'(1);
      sel_data_q <= '0;
      hmaster_q <= '0;
      rem_q <= '0;
`ifndef AHB_ARB_FIXED_PRIO_EN
      last_q <= '0;
`endif
    end else begin
      sel_addr_q <= sel_addr_d;
      sel_data_q <= sel_data_d;
      hmaster_q <= hmaster_d;
      rem_q <= rem_d;
`ifndef AHB_ARB_FIXED_PRIO_EN
      last_q <= last_d;
`endif
    end
  end
  assign sel_addr = sel_addr_q;
  assign sel_data = sel_data_q;
  assign hmaster = hmaster_q;
endmodule

// File: tb/tb_ahb_arbiter_slave_inst.sv
// tb_ahb_arbiter_slave_inst: directed round-robin, burst, stall, lock and reset checks
module tb_ahb_arbiter_slave_inst;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011, INCR8 = 3'b101, INCR16 = 3'b111;
  logic            hclk, hreset, hready;
  logic [3:0]      hreq, hmastlock, sel_addr, sel_data;
  logic [3:0][1:0] htrans;
  logic [3:0][2:0] hburst;
  logic [1:0]      hmaster;
  int checks = 0;
  int errors = 0;
  ahb_arbiter_slave_inst #(.CHANNEL_NUM(4)) dut (
    .hclk(hclk), .hreset(hreset), .hreq(hreq), .htrans(htrans), .hburst(hburst),
    .hmastlock(hmastlock), .hready(hready), .sel_addr(sel_addr), .sel_data(sel_data), .hmaster(hmaster)
  );
  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] sa, input logic [3:0] sd, input logic [1:0] hm);
    checks++;
    assert (sel_addr === sa && sel_data === sd && hmaster === hm) else begin
      errors++;
      $error("FAIL %s: got sel_addr=%b sel_data=%b hmaster=%0d want sel_addr=%b sel_data=%b hmaster=%0d",
             tag, sel_addr, sel_data, hmaster, sa, sd, hm);
    end
  endtask
  initial begin
    hreset = 1'b1; hready = 1'b1; hreq = '0; hmastlock = '0; htrans = '0; hburst = '0;
    tick(); tick();
    chk("reset", 4'b0001, 4'b0000, 2'd0);
    hreset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("park", 4'b0001, 4'b0001, 2'd0);
    end
    hreq = 4'b0110; htrans[1] = NSEQ; htrans[2] = NSEQ;
    tick(); chk("rr1", 4'b0010, 4'b0001, 2'd1);
    tick(); chk("rr2", 4'b0100, 4'b0010, 2'd2);
    tick(); chk("rr3", 4'b0010, 4'b0100, 2'd1);
    tick(); chk("rr4", 4'b0100, 4'b0010, 2'd2);
    hreq = '0; htrans = '0;
    tick(); chk("park2", 4'b0100, 4'b0100, 2'd2);
    hreq = 4'b0010; htrans[1] = NSEQ; hburst[1] = INCR4;
    tick(); chk("i4_grant", 4'b0010, 4'b0100, 2'd1);
    hreq = 4'b1010; htrans[3] = NSEQ;
    tick(); chk("i4_b1", 4'b0010, 4'b0010, 2'd1);
    htrans[1] = SEQ;
    tick(); chk("i4_b2", 4'b0010, 4'b0010, 2'd1);
    tick(); chk("i4_b3", 4'b0010, 4'b0010, 2'd1);
    tick(); chk("i4_b4_switch", 4'b1000, 4'b0010, 2'd3);
    htrans[1] = NSEQ;
    tick(); chk("busy_grant", 4'b0010, 4'b1000, 2'd1);
    tick(); chk("busy_b1", 4'b0010, 4'b0010, 2'd1);
    htrans[1] = SEQ;
    tick(); chk("busy_b2", 4'b0010, 4'b0010, 2'd1);
    htrans[1] = BUSY;
    tick(); chk("busy_idle", 4'b0010, 4'b0010, 2'd1);
    htrans[1] = SEQ;
    tick(); chk("busy_b3", 4'b0010, 4'b0010, 2'd1);
    tick(); chk("busy_b4_switch", 4'b1000, 4'b0010, 2'd3);
    hreq = 4'b1100; htrans[1] = IDLE; htrans[2] = NSEQ; hburst[2] = INCR8;
    tick(); chk("i8_grant", 4'b0100, 4'b1000, 2'd2);
    tick(); chk("i8_b1", 4'b0100, 4'b0100, 2'd2);
    htrans[2] = SEQ;
    tick(); chk("i8_b2", 4'b0100, 4'b0100, 2'd2);
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("i8_stall", 4'b0100, 4'b0100, 2'd2);
    end
    hready = 1'b1;
    for (int i = 3; i <= 7; i++) begin
      tick();
      chk($sformatf("i8_b%0d", i), 4'b0100, 4'b0100, 2'd2);
    end
    tick(); chk("i8_b8_switch", 4'b1000, 4'b0100, 2'd3);
    hready = 1'b0; htrans[3] = IDLE; hreq = 4'b0011;
    tick(); chk("stall_no_arb", 4'b1000, 4'b0100, 2'd3);
    hready = 1'b1; htrans[2] = IDLE; htrans[0] = NSEQ; htrans[1] = NSEQ; hmastlock[0] = 1'b1;
    tick(); chk("lk_grant", 4'b0001, 4'b1000, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lk_hold", 4'b0001, 4'b0001, 2'd0);
    end
    htrans[0] = IDLE;
    tick(); chk("lk_idle_hold", 4'b0001, 4'b0001, 2'd0);
    hmastlock[0] = 1'b0;
    tick(); chk("lk_release", 4'b0010, 4'b0001, 2'd1);
    hreq = 4'b0110; htrans[1] = NSEQ; hburst[1] = INCR16;
    tick(); chk("i16_b1", 4'b0010, 4'b0010, 2'd1);
    htrans[1] = SEQ;
    tick(); chk("i16_b2", 4'b0010, 4'b0010, 2'd1);
    hreset = 1'b1;
    tick(); chk("i16_reset", 4'b0001, 4'b0000, 2'd0);
    hreset = 1'b0; htrans[0] = SEQ; htrans[1] = IDLE;
    tick(); chk("post_reset_arb", 4'b0010, 4'b0001, 2'd1);
    hreq = 4'b0100; hburst[1] = INCR; htrans[1] = SEQ;
    tick(); chk("incr_hold", 4'b0010, 4'b0010, 2'd1);
    htrans[1] = IDLE;
    tick(); chk("incr_end", 4'b0100, 4'b0010, 2'd2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
